// File: rtl/systolic_array_ctrl.sv
// Controller for a 4x4 weight-stationary systolic array: streams in 16 weights,
// then feeds activation/bias vectors with skew and deskews the row results.
module systolic_array_ctrl #(
  parameter int ACT_W     = 9,
  parameter int PSUM_W    = 13,
  parameter int VEC_CNT_W = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  reuse_weights_in,
  input  logic [VEC_CNT_W-1:0]  num_vec_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  weights_valid_out,
  input  logic [ACT_W-1:0]      weight_data_in,
  input  logic                  weight_valid_in,
  output logic                  weight_ready_out,
  input  logic [4*ACT_W-1:0]    act_vec_in,
  input  logic [4*PSUM_W-1:0]   bias_vec_in,
  input  logic                  act_valid_in,
  output logic                  act_ready_out,
  output logic [4*PSUM_W-1:0]   res_vec_out,
  output logic                  res_valid_out,
  output logic                  load_weight_out,
  output logic [ACT_W-1:0]      weight_out,
  output logic [ACT_W-1:0]      activation_column_0_out,
  output logic [ACT_W-1:0]      activation_column_1_out,
  output logic [ACT_W-1:0]      activation_column_2_out,
  output logic [ACT_W-1:0]      activation_column_3_out,
  output logic [PSUM_W-1:0]     psum_row_0_out,
  output logic [PSUM_W-1:0]     psum_row_1_out,
  output logic [PSUM_W-1:0]     psum_row_2_out,
  output logic [PSUM_W-1:0]     psum_row_3_out,
  input  logic [PSUM_W-1:0]     psum_row_0_in,
  input  logic [PSUM_W-1:0]     psum_row_1_in,
  input  logic [PSUM_W-1:0]     psum_row_2_in,
  input  logic [PSUM_W-1:0]     psum_row_3_in
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_WAIT_ACT, S_FEED} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_done;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_weights_valid;
  logic                   r_weight_ready;
  logic                   r_act_ready;
  logic                   r_res_valid;
  logic                   r_load_weight;
  logic [ACT_W-1:0]       r_weight_out;
  logic [3:0]             r_wcnt;
  logic [3:0]             r_phase;
  logic [VEC_CNT_W-1:0]   r_num_vec;
  logic [VEC_CNT_W-1:0]   r_vec_cnt;
  logic [3*ACT_W-1:0]     r_act_hi;
  logic [4*PSUM_W-1:0]    r_bias_lat;
  logic [ACT_W-1:0]       r_col [4];
  logic [PSUM_W-1:0]      r_psum [4];
  logic [PSUM_W-1:0]      r_res [4];

  logic [PSUM_W-1:0]      w_psum_in [4];
  logic                   w_beat;
  logic                   w_accept;
  logic                   w_last_beat;
  logic                   w_feed_end;
  logic                   w_last_vec;
  logic                   w_start_reuse;
  logic [VEC_CNT_W-1:0]   w_vec_cnt_nxt;
  logic [1:0]             w_col_sel;
  logic [1:0]             w_res_sel;

  assign w_psum_in[0]  = psum_row_0_in;
  assign w_psum_in[1]  = psum_row_1_in;
  assign w_psum_in[2]  = psum_row_2_in;
  assign w_psum_in[3]  = psum_row_3_in;

  assign w_beat        = r_weight_ready & weight_valid_in;
  assign w_accept      = r_act_ready & act_valid_in;
  assign w_last_beat   = w_beat && (r_wcnt == 4'd15);
  assign w_feed_end    = (r_state == S_FEED) && (r_phase == 4'd9);
  assign w_vec_cnt_nxt = r_vec_cnt + VEC_CNT_W'(1);
  assign w_last_vec    = (w_vec_cnt_nxt == r_num_vec);
  assign w_start_reuse = reuse_weights_in & r_weights_valid;
  // Phase p feeds column p (slices 1..3 kept in r_act_hi) and captures row p-6.
  assign w_col_sel     = r_phase[1:0] - 2'd1;
  assign w_res_sel     = r_phase[1:0] - 2'd2;

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns w_next/w_done and no latch is inferred.
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          if (!w_start_reuse)          w_next = S_LOAD_W;
          else if (num_vec_in == '0)   w_done = 1'b1;
          else                         w_next = S_WAIT_ACT;
        end
      end
      S_LOAD_W: begin
        if (w_last_beat) begin
          if (r_num_vec == '0) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_next = S_WAIT_ACT;
          end
        end
      end
      S_WAIT_ACT: if (w_accept) w_next = S_FEED;
      S_FEED: begin
        if (w_feed_end) begin
          if (w_last_vec) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_next = S_WAIT_ACT;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_weights_valid <= 1'b0;
      r_weight_ready  <= 1'b0;
      r_act_ready     <= 1'b0;
      r_res_valid     <= 1'b0;
      r_load_weight   <= 1'b0;
      r_weight_out    <= '0;
      r_wcnt          <= '0;
      r_num_vec       <= '0;
      r_vec_cnt       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      r_busy         <= (w_next != S_IDLE);
      r_weight_ready <= (w_next == S_LOAD_W);
      r_act_ready    <= (w_next == S_WAIT_ACT);
      r_done         <= w_done;
      r_res_valid    <= w_feed_end;
      r_load_weight  <= w_beat;
      if (w_beat) begin
        r_weight_out <= weight_data_in;
        r_wcnt       <= r_wcnt + 4'd1;
      end
      if (r_state == S_IDLE && start_in) begin
        r_num_vec <= num_vec_in;
        r_vec_cnt <= '0;
        r_wcnt    <= '0;
        if (!w_start_reuse) r_weights_valid <= 1'b0;
      end else if (w_last_beat) begin
        r_weights_valid <= 1'b1;
      end
      if (w_feed_end) r_vec_cnt <= w_vec_cnt_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      // NOTE: the holding registers are reset too, since every output must read 0 after reset.
      r_phase    <= '0;
      r_act_hi   <= '0;
      r_bias_lat <= '0;
      for (int k = 0; k < 4; k++) begin
        r_col[k]  <= '0;
        r_psum[k] <= '0;
        r_res[k]  <= '0;
      end
    end else if (w_accept) begin
      r_act_hi   <= act_vec_in[4*ACT_W-1:ACT_W];
      r_bias_lat <= bias_vec_in;
      r_col[0]   <= act_vec_in[ACT_W-1:0];
      r_phase    <= 4'd1;
    end else if (r_state == S_FEED) begin
      r_phase <= r_phase + 4'd1;
      if (r_phase >= 4'd1 && r_phase <= 4'd3)
        r_col[r_phase[1:0]] <= r_act_hi[w_col_sel*ACT_W +: ACT_W];
      if (r_phase >= 4'd4 && r_phase <= 4'd7)
        r_psum[r_phase[1:0]] <= r_bias_lat[r_phase[1:0]*PSUM_W +: PSUM_W];
      if (r_phase >= 4'd6 && r_phase <= 4'd9)
        r_res[w_res_sel] <= w_psum_in[w_res_sel];
    end
  end

  assign busy_out                = r_busy;
  assign done_out                = r_done;
  assign weights_valid_out       = r_weights_valid;
  assign weight_ready_out        = r_weight_ready;
  assign act_ready_out           = r_act_ready;
  assign res_valid_out           = r_res_valid;
  assign res_vec_out             = {r_res[3], r_res[2], r_res[1], r_res[0]};
  assign load_weight_out         = r_load_weight;
  assign weight_out              = r_weight_out;
  assign activation_column_0_out = r_col[0];
  assign activation_column_1_out = r_col[1];
  assign activation_column_2_out = r_col[2];
  assign activation_column_3_out = r_col[3];
  assign psum_row_0_out          = r_psum[0];
  assign psum_row_1_out          = r_psum[1];
  assign psum_row_2_out          = r_psum[2];
  assign psum_row_3_out          = r_psum[3];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: behavioural 4x4 array model, vector table with
// hand-computed sums, and directed sequences for reuse, reset and start corner cases.
module tb_systolic_array_ctrl;
  localparam int ACT_W     = 9;
  localparam int PSUM_W    = 13;
  localparam int VEC_CNT_W = 8;
  localparam int HMAX      = 4096;

  logic                  clk_in, rst_in, start_in, reuse_weights_in;
  logic [VEC_CNT_W-1:0]  num_vec_in;
  logic                  busy_out, done_out, weights_valid_out;
  logic [ACT_W-1:0]      weight_data_in;
  logic                  weight_valid_in, weight_ready_out;
  logic [4*ACT_W-1:0]    act_vec_in;
  logic [4*PSUM_W-1:0]   bias_vec_in;
  logic                  act_valid_in, act_ready_out;
  logic [4*PSUM_W-1:0]   res_vec_out;
  logic                  res_valid_out, load_weight_out;
  logic [ACT_W-1:0]      weight_out;
  logic [ACT_W-1:0]      col [4];
  logic [PSUM_W-1:0]     pout [4];
  logic [PSUM_W-1:0]     pin [4];

  systolic_array_ctrl #(.ACT_W(ACT_W), .PSUM_W(PSUM_W), .VEC_CNT_W(VEC_CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .reuse_weights_in(reuse_weights_in), .num_vec_in(num_vec_in),
    .busy_out(busy_out), .done_out(done_out), .weights_valid_out(weights_valid_out),
    .weight_data_in(weight_data_in), .weight_valid_in(weight_valid_in),
    .weight_ready_out(weight_ready_out), .act_vec_in(act_vec_in), .bias_vec_in(bias_vec_in),
    .act_valid_in(act_valid_in), .act_ready_out(act_ready_out), .res_vec_out(res_vec_out),
    .res_valid_out(res_valid_out), .load_weight_out(load_weight_out), .weight_out(weight_out),
    .activation_column_0_out(col[0]), .activation_column_1_out(col[1]),
    .activation_column_2_out(col[2]), .activation_column_3_out(col[3]),
    .psum_row_0_out(pout[0]), .psum_row_1_out(pout[1]),
    .psum_row_2_out(pout[2]), .psum_row_3_out(pout[3]),
    .psum_row_0_in(pin[0]), .psum_row_1_in(pin[1]),
    .psum_row_2_in(pin[2]), .psum_row_3_in(pin[3])
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Array model: row k output = incoming psum + dot(weight row k, current columns).
  logic [ACT_W-1:0] model_w [16];
  logic [3:0]       model_idx;
  logic [31:0]      acc;
  always_comb begin
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      acc = 32'(pout[k]);
      for (int c = 0; c < 4; c++) acc = acc + 32'(model_w[4*k+c]) * 32'(col[c]);
      pin[k] = acc[PSUM_W-1:0];
    end
  end

  typedef struct {
    logic [4*ACT_W-1:0]  act;
    logic [4*PSUM_W-1:0] bias;
    logic [4*PSUM_W-1:0] exp;
  } vec_t;
  vec_t tbl [5];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lw_cnt   = 0;
  logic [ACT_W-1:0]    lw_seq [64];
  logic [4*ACT_W-1:0]  h_col  [HMAX];
  logic [4*PSUM_W-1:0] h_psum [HMAX];
  logic [4*PSUM_W-1:0] h_res  [HMAX];
  logic                h_rv [HMAX], h_done [HMAX], h_busy [HMAX];
  logic                h_ar [HMAX], h_wr [HMAX], h_wv [HMAX], h_any [HMAX];
  int                  e_acc [4];

  // Snapshot of every output 1 time unit after each rising edge, indexed by edge number.
  always @(posedge clk_in) begin
    cyc = cyc + 1;
    #1;
    if (!rst_in) model_idx = '0;
    if (load_weight_out) begin
      model_w[model_idx] = weight_out;
      model_idx = model_idx + 4'd1;
      if (lw_cnt < 64) lw_seq[lw_cnt] = weight_out;
      lw_cnt++;
    end
    if (cyc < HMAX) begin
      h_col[cyc]  = {col[3], col[2], col[1], col[0]};
      h_psum[cyc] = {pout[3], pout[2], pout[1], pout[0]};
      h_res[cyc]  = res_vec_out;
      h_rv[cyc]   = res_valid_out;
      h_done[cyc] = done_out;
      h_busy[cyc] = busy_out;
      h_ar[cyc]   = act_ready_out;
      h_wr[cyc]   = weight_ready_out;
      h_wv[cyc]   = weights_valid_out;
      h_any[cyc]  = |{busy_out, done_out, weights_valid_out, weight_ready_out, act_ready_out,
                      load_weight_out, weight_out, res_vec_out, res_valid_out,
                      col[0], col[1], col[2], col[3], pout[0], pout[1], pout[2], pout[3]};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_job(input logic reuse, input logic [VEC_CNT_W-1:0] nv, output int s);
    @(negedge clk_in);
    start_in = 1'b1; reuse_weights_in = reuse; num_vec_in = nv;
    s = cyc + 1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic load_weights();
    int idx = 0;
    int t = 0;
    while (idx < 16 && t < 200) begin
      @(negedge clk_in);
      weight_valid_in = (t % 3 != 2);
      weight_data_in  = ACT_W'(idx);
      if (weight_valid_in && weight_ready_out) idx++;
      t++;
    end
    @(negedge clk_in);
    weight_valid_in = 1'b0;
    check("weight_beats_accepted", 64'(idx), 64'd16);
  endtask

  task automatic drive_vectors(input int first, input int n, input bit pulse_start);
    int t;
    for (int v = 0; v < n; v++) begin
      act_vec_in   = tbl[first+v].act;
      bias_vec_in  = tbl[first+v].bias;
      act_valid_in = 1'b1;
      if (pulse_start && v == 1) begin
        start_in = 1'b1; num_vec_in = '0;
        @(negedge clk_in);
        start_in = 1'b0;
      end
      t = 0;
      while (!act_ready_out && t < 100) begin
        @(negedge clk_in);
        t++;
      end
      check($sformatf("vec%0d_accepted_in_time", first + v), 64'(t < 100), 64'd1);
      e_acc[v] = cyc + 1;
      @(negedge clk_in);
    end
    act_valid_in = 1'b0;
  endtask

  task automatic wait_done(output int d);
    int t = 0;
    while (!done_out && t < 100) begin
      @(negedge clk_in);
      t++;
    end
    check("done_seen", 64'(done_out), 64'd1);
    d = cyc;
    @(negedge clk_in);
  endtask

  int s, d, e0, lw_before, cnt_rv, cnt_done;
  logic [4*ACT_W-1:0]  exp_col;
  logic [4*PSUM_W-1:0] exp_ps;

  initial begin
    // Weights are 0..15 row-major, so row k = {4k, 4k+1, 4k+2, 4k+3}; column 0 is the LSB slice.
    tbl[0].act = {9'd4, 9'd3, 9'd2, 9'd1};     tbl[0].bias = '0;
    tbl[0].exp = {13'd140, 13'd100, 13'd60, 13'd20};
    tbl[1].act = {9'd1, 9'd1, 9'd1, 9'd7};     tbl[1].bias = {13'd8, 13'd7, 13'd6, 13'd5};
    tbl[1].exp = {13'd134, 13'd93, 13'd52, 13'd11};
    tbl[2].act = {9'd0, 9'd0, 9'd0, 9'd10};    tbl[2].bias = {13'd1, 13'd0, 13'd0, 13'd100};
    tbl[2].exp = {13'd121, 13'd80, 13'd40, 13'd100};
    tbl[3].act = {9'd2, 9'd0, 9'd0, 9'd0};     tbl[3].bias = '0;
    tbl[3].exp = {13'd30, 13'd22, 13'd14, 13'd6};
    tbl[4].act = {9'd511, 9'd511, 9'd511, 9'd511}; tbl[4].bias = '0;
    tbl[4].exp = {13'd3018, 13'd3034, 13'd3050, 13'd3066};   // wraps modulo 2^13

    for (int i = 0; i < 16; i++) model_w[i] = '0;
    model_idx = '0;
    rst_in = 1'b0; start_in = 1'b0; reuse_weights_in = 1'b0; num_vec_in = '0;
    weight_data_in = '0; weight_valid_in = 1'b0;
    act_vec_in = '0; bias_vec_in = '0; act_valid_in = 1'b0;

    repeat (3) @(negedge clk_in);
    check("reset_outputs_zero", 64'(h_any[cyc]), 64'd0);
    check("reset_weights_valid", 64'(weights_valid_out), 64'd0);
    rst_in = 1'b1;

    // Job A: full load with stalls, then one vector.
    start_job(1'b0, 8'd1, s);
    check("jobA_weight_ready_after_start", 64'(h_wr[s]), 64'd1);
    load_weights();
    check("jobA_load_pulses", 64'(lw_cnt), 64'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("jobA_weight_seq%0d", i), 64'(lw_seq[i]), 64'(i));
    check("jobA_weights_valid", 64'(weights_valid_out), 64'd1);
    drive_vectors(0, 1, 1'b0);
    e0 = e_acc[0];
    wait_done(d);
    for (int t = 0; t < 5; t++) begin
      exp_col = '0;
      for (int k = 0; k < 4; k++)
        if (t >= k) exp_col[k*ACT_W +: ACT_W] = tbl[0].act[k*ACT_W +: ACT_W];
      check($sformatf("jobA_col_skew_t%0d", t), 64'(h_col[e0+t]), 64'(exp_col));
    end
    check("jobA_res_valid_early", 64'(h_rv[e0+8]), 64'd0);
    check("jobA_res_valid", 64'(h_rv[e0+9]), 64'd1);
    check("jobA_res_valid_width", 64'(h_rv[e0+10]), 64'd0);
    check("jobA_done_edge", 64'(d), 64'(e0 + 9));
    check("jobA_idle_after", 64'(h_busy[e0+9]), 64'd0);

    // Job B: reuse, three vectors with valid held high; stray start while busy.
    lw_before = lw_cnt;
    start_job(1'b1, 8'd3, s);
    check("jobB_act_ready_after_start", 64'(h_ar[s]), 64'd1);
    drive_vectors(1, 3, 1'b1);
    wait_done(d);
    check("jobB_no_weight_load", 64'(lw_cnt), 64'(lw_before));
    check("jobB_first_accept", 64'(e_acc[0]), 64'(s + 1));
    check("jobB_spacing01", 64'(e_acc[1] - e_acc[0]), 64'd10);
    check("jobB_spacing12", 64'(e_acc[2] - e_acc[1]), 64'd10);
    check("jobB_done_edge", 64'(d), 64'(e_acc[2] + 9));
    for (int t = 3; t < 9; t++) begin
      exp_ps = '0;
      for (int k = 0; k < 4; k++)
        if (t >= 4 + k) exp_ps[k*PSUM_W +: PSUM_W] = tbl[1].bias[k*PSUM_W +: PSUM_W];
      check($sformatf("jobB_psum_skew_t%0d", t), 64'(h_psum[e_acc[0]+t]), 64'(exp_ps));
    end
    cnt_rv = 0; cnt_done = 0;
    for (int c = s; c <= d + 2; c++) begin
      cnt_rv   += int'(h_rv[c]);
      cnt_done += int'(h_done[c]);
    end
    check("jobB_res_valid_count", 64'(cnt_rv), 64'd3);
    check("jobB_done_count", 64'(cnt_done), 64'd1);

    // Table-driven result check for the vectors of jobs A and B.
    e_acc[3] = e0;
    for (int v = 0; v < 4; v++) begin
      e0 = (v == 0) ? e_acc[3] : e_acc[v-1];
      check($sformatf("vec%0d_res_valid", v), 64'(h_rv[e0+9]), 64'd1);
      check($sformatf("vec%0d_result", v), 64'(h_res[e0+9]), 64'(tbl[v].exp));
    end

    // Job C: overflow vector.
    start_job(1'b1, 8'd1, s);
    drive_vectors(4, 1, 1'b0);
    wait_done(d);
    check("vec4_result_wrap", 64'(h_res[e_acc[0]+9]), 64'(tbl[4].exp));

    // Job D: zero vectors with reuse completes immediately.
    start_job(1'b1, 8'd0, s);
    @(negedge clk_in);
    check("jobD_done_after_start", 64'(h_done[s]), 64'd1);
    check("jobD_not_busy", 64'(h_busy[s]), 64'd0);
    check("jobD_done_one_cycle", 64'(h_done[s+1]), 64'd0);

    // Job E: reset sampled at E0+5 in the middle of a vector.
    start_job(1'b1, 8'd1, s);
    drive_vectors(2, 1, 1'b0);
    e0 = e_acc[0];
    while (cyc < e0 + 4) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    check("jobE_outputs_zero_after_reset", 64'(h_any[e0+5]), 64'd0);
    check("jobE_weights_invalid", 64'(h_wv[e0+5]), 64'd0);
    repeat (15) @(negedge clk_in);
    cnt_rv = 0; cnt_done = 0;
    for (int c = e0 + 5; c < e0 + 20; c++) begin
      cnt_rv   += int'(h_rv[c]);
      cnt_done += int'(h_done[c]);
    end
    check("jobE_no_res_valid", 64'(cnt_rv), 64'd0);
    check("jobE_no_done", 64'(cnt_done), 64'd0);

    // Job F: reuse requested after reset still does a full load.
    lw_before = lw_cnt;
    start_job(1'b1, 8'd1, s);
    check("jobF_no_act_ready", 64'(h_ar[s]), 64'd0);
    check("jobF_weight_ready", 64'(h_wr[s]), 64'd1);
    load_weights();
    check("jobF_load_pulses", 64'(lw_cnt - lw_before), 64'd16);
    drive_vectors(0, 1, 1'b0);
    wait_done(d);
    check("jobF_result", 64'(h_res[e_acc[0]+9]), 64'(tbl[0].exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter ACT_W, default 9, activation and weight width.
REQ-002 SHALL have parameter PSUM_W, default 13, partial-sum width.
REQ-003 SHALL have parameter VEC_CNT_W, default 8, width of the vector count.
REQ-004 clk_in  input  1  single clock; all logic on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 start_in  input  1  job start pulse; sampled only in IDLE.
REQ-007 reuse_weights_in  input  1  skip weight load if weights_valid_out=1.
REQ-008 num_vec_in  input  VEC_CNT_W  vectors in job; latched at start.
REQ-009 busy_out / done_out  output  1 each  busy = not IDLE; done = 1-cycle job-complete pulse.
REQ-010 weights_valid_out  output  1  array holds a complete 16-weight set.
REQ-011 weight_data_in / weight_valid_in / weight_ready_out  in/in/out  ACT_W/1/1  weight stream, row-major, element 0 first.
REQ-012 act_vec_in / bias_vec_in  input  4*ACT_W / 4*PSUM_W  column k / row k in slice k (k=0 LSB).
REQ-013 act_valid_in / act_ready_out  in/out  1/1  vector handshake; act and bias transfer together.
REQ-014 res_vec_out / res_valid_out  output  4*PSUM_W / 1  deskewed result; row k in slice k; no backpressure.
REQ-015 load_weight_out / weight_out  output  1 / ACT_W  to array load_weight_in / weight_in.
REQ-016 activation_column_k_out (k=0..3)  output  ACT_W  to array column k.
REQ-017 psum_row_k_out (k=0..3)  output  PSUM_W  to array psum row k input.
REQ-018 psum_row_k_in (k=0..3)  input  PSUM_W  from array psum row k output.

Function
REQ-019 States SHALL be IDLE, LOAD_W, WAIT_ACT, FEED; all outputs registered.
REQ-020 IDLE + start_in: to LOAD_W if reuse_weights_in=0 or weights_valid_out=0, else to WAIT_ACT; start_in outside IDLE ignored.
REQ-021 On start, weights_valid_out SHALL clear when entering LOAD_W.
REQ-022 LOAD_W: weight_ready_out=1; each accepted beat registers weight_out and sets load_weight_out=1 for the following cycle; no beat -> load_weight_out=0, weight_out held.
REQ-023 A 4-bit counter SHALL count accepted beats; the 16th sets weights_valid_out=1 and transitions to WAIT_ACT (or to IDLE with done_out if latched num_vec=0).
REQ-024 WAIT_ACT: act_ready_out=1, only state where it is high; accept edge = E0; transition to FEED.
REQ-025 activation_column_k_out SHALL load slice k of the accepted vector at edge E0+k (column 0 at E0), held until next vector.
REQ-026 psum_row_k_out SHALL load bias slice k at edge E0+4+k, held until next vector.
REQ-027 Result slice k SHALL capture psum_row_k_in at edge E0+6+k.
REQ-028 res_valid_out SHALL be 1 for exactly the cycle after E0+9; res_vec_out held until next capture.
REQ-029 At E0+9: vector counter increments; if it equals latched num_vec -> IDLE with done_out=1 same cycle as final res_valid_out, else -> WAIT_ACT.
REQ-030 Max throughput one vector per 10 cycles (earliest next accept E0+10).
REQ-031 Vector counter SHALL not wrap: num_vec=255 runs exactly 255 vectors.
REQ-032 load_weight_out SHALL be 0 in every state except the cycle following an accepted weight beat.

Reset
REQ-033 rst_in=0 at any edge, including mid-LOAD_W/FEED, SHALL force IDLE; all outputs, counters, latches 0; weights_valid_out=0; partial results discarded, no done_out.
REQ-034 After reset, the next job SHALL perform a full weight load regardless of reuse_weights_in.

Verification
REQ-035 Weights 0..15 with weight_valid_in low every third cycle -> load_weight_out high exactly 16 cycles, weight_out sequence 0..15, weights_valid_out=1 after the 16th.
REQ-036 One vector act={4,3,2,1}, bias={0,0,0,0} on behavioural array model -> column k changes at E0+k, psum row k at E0+4+k, res_valid_out one cycle after E0+9 with model-expected sums.
REQ-037 num_vec=3, act_valid_in held high -> accepts at E0, E0+10, E0+20; 3 res_valid_out pulses; done_out coincident with the third.
REQ-038 Second job reuse_weights_in=1 -> no load_weight_out, act_ready_out the cycle after start; reuse after reset -> full 16-beat load.
REQ-039 rst_in low 1 cycle at E0+5 -> all outputs 0 next cycle, no res_valid_out, no done_out, weights_valid_out=0.
REQ-040 num_vec=0 with reuse -> done_out the cycle after start; start_in pulsed while busy -> ignored, num_vec latch unchanged.
